// File: rtl/tnn_neuron_sequencer.sv
// Sequences NUM_NEUR logical TNN neurons onto one shared combinational neuron.
// Per-neuron operand routing comes from a writable table; results are majority-voted.
module tnn_neuron_sequencer #(
  parameter int NUM_FEAT = 9,
  parameter int NUM_NEUR = 5,
  parameter int SEL_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*NUM_FEAT-1:0] in_features,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_neur,
  input  logic [2:0]            cfg_slot,
  input  logic [SEL_W-1:0]      cfg_idx,
  output logic [13:0]           neur_in,
  input  logic                  neur_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NUM_NEUR-1:0]   out_vec,
  output logic                  out_class,
  output logic                  busy,
  output logic                  cfg_drop
);

  localparam int NUM_ENT = NUM_NEUR * 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CAPT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_r, state_next_s;
  logic [2*NUM_FEAT-1:0] feat_r;
  logic [2:0]            n_r;
  logic [SEL_W-1:0]      route_r [NUM_ENT];
  logic [13:0]           ops_s;
  logic [NUM_NEUR-1:0]   vec_next_s;
  logic                  class_next_s;
  logic                  cfg_open_s;
  logic                  cfg_addr_ok_s;
  logic                  last_s;

  // Out-of-range indices select a zero operand.
  function automatic logic [1:0] pick_feat(input logic [2*NUM_FEAT-1:0] feat,
                                           input logic [SEL_W-1:0] idx);
    logic [1:0] op;
    op = 2'b00;
    for (int i = 0; i < NUM_FEAT; i++) begin
      if (idx == SEL_W'(i)) begin
        op = feat[2*i +: 2];
      end else begin
        op = op;
      end
    end
    return op;
  endfunction

  assign cfg_open_s    = (state_r == IDLE) || (state_r == DONE);
  assign cfg_addr_ok_s = ({1'b0, cfg_neur} < 4'(NUM_NEUR)) && (cfg_slot != 3'd7);
  assign last_s        = (n_r == 3'(NUM_NEUR - 1));

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = in_valid ? DRIVE : IDLE;
      DRIVE:   state_next_s = CAPT;
      CAPT:    state_next_s = last_s ? DONE : DRIVE;
      DONE:    state_next_s = out_ready ? IDLE : DONE;
      default: state_next_s = IDLE;
    endcase
  end

  // Operand mux for the neuron currently selected by n_r.
  always_comb begin
    ops_s = 14'd0;
    for (int n = 0; n < NUM_NEUR; n++) begin
      for (int s = 0; s < 7; s++) begin
        if (n_r == 3'(n)) begin
          ops_s[2*s +: 2] = pick_feat(feat_r, route_r[n*7 + s]);
        end else begin
          ops_s[2*s +: 2] = ops_s[2*s +: 2];
        end
      end
    end
  end

  // Firing vector with the current capture merged in, and its majority vote.
  always_comb begin
    logic [3:0] cnt;
    vec_next_s = out_vec;
    cnt        = 4'd0;
    for (int n = 0; n < NUM_NEUR; n++) begin
      if (n_r == 3'(n)) begin
        vec_next_s[n] = neur_out;
      end else begin
        vec_next_s[n] = out_vec[n];
      end
      cnt = cnt + 4'(vec_next_s[n]);
    end
    class_next_s = (cnt > 4'(NUM_NEUR / 2));
  end

  // Routing table: defaults on reset, writes only while not evaluating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_NEUR; n++) begin
        for (int s = 0; s < 7; s++) begin
          route_r[n*7 + s] <= SEL_W'((n + s) % NUM_FEAT);
        end
      end
    end else if (cfg_we && cfg_open_s && cfg_addr_ok_s) begin
      for (int n = 0; n < NUM_NEUR; n++) begin
        for (int s = 0; s < 7; s++) begin
          if (cfg_neur == 3'(n) && cfg_slot == 3'(s)) begin
            route_r[n*7 + s] <= cfg_idx;
          end
        end
      end
    end
  end

  // Sequencer state, datapath registers and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      feat_r    <= '0;
      n_r       <= 3'd0;
      neur_in   <= 14'd0;
      out_vec   <= '0;
      out_class <= 1'b0;
      cfg_drop  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      in_ready  <= (state_next_s == IDLE);
      out_valid <= (state_next_s == DONE);
      busy      <= (state_next_s == DRIVE) || (state_next_s == CAPT);
      if (cfg_we && !cfg_open_s) begin
        cfg_drop <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            feat_r <= in_features;
            n_r    <= 3'd0;
          end
        end
        DRIVE: neur_in <= ops_s;
        CAPT: begin
          out_vec <= vec_next_s;
          if (last_s) begin
            out_class <= class_next_s;
          end else begin
            n_r <= n_r + 3'd1;
          end
        end
        DONE:    ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tnn_neuron_sequencer.sv
// Directed self-checking bench for tnn_neuron_sequencer with a timing-driven neuron stub.
module tb_tnn_neuron_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_features;
  logic        cfg_we;
  logic [2:0]  cfg_neur;
  logic [2:0]  cfg_slot;
  logic [3:0]  cfg_idx;
  logic [13:0] neur_in;
  logic        neur_out;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_vec;
  logic        out_class;
  logic        busy;
  logic        cfg_drop;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 100;
  logic [4:0]  fire_mask = 5'd0;

  localparam logic [17:0] F1 = {2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
  localparam logic [17:0] F2 = {2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
  localparam logic [17:0] F3 = 18'h3FFFF;

  tnn_neuron_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_features(in_features), .cfg_we(cfg_we), .cfg_neur(cfg_neur),
    .cfg_slot(cfg_slot), .cfg_idx(cfg_idx), .neur_in(neur_in), .neur_out(neur_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .out_class(out_class), .busy(busy), .cfg_drop(cfg_drop)
  );

  always #5 clk = ~clk;

  // Cycles since the last accept; neuron k is captured while cyc is 2k+1.
  always @(posedge clk) begin
    if (rst) cyc <= 100;
    else if (in_valid && in_ready) cyc <= 0;
    else if (cyc < 100) cyc <= cyc + 1;
  end

  assign neur_out = (cyc >= 1 && cyc <= 10) ? fire_mask[(cyc - 1) / 2] : 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one sample from IDLE, optionally with a simultaneous config write.
  task automatic start(input logic [17:0] f, input logic [4:0] mask,
                       input logic do_cfg, input logic [3:0] idx);
    @(negedge clk);
    check_val("start_in_ready", in_ready, 1);
    in_features = f;
    in_valid    = 1'b1;
    fire_mask   = mask;
    cfg_we      = do_cfg;
    cfg_neur    = 3'd0;
    cfg_slot    = 3'd0;
    cfg_idx     = idx;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
  endtask

  // Walk from the negedge after accept to DONE, checking operands and results.
  task automatic run_body(input logic [13:0] n0, input logic [13:0] n1,
                          input logic [4:0] vec, input logic cls, input logic busy_cfg);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check_val("neur_in_n0", neur_in, n0);
        check_val("busy_run", busy, 1);
        check_val("in_ready_run", in_ready, 0);
      end
      if (k == 2 && busy_cfg) begin
        cfg_we = 1'b1; cfg_neur = 3'd0; cfg_slot = 3'd0; cfg_idx = 4'd8;
      end
      if (k == 3) begin
        cfg_we = 1'b0;
        check_val("neur_in_n1", neur_in, n1);
        if (busy_cfg) check_val("cfg_drop_set", cfg_drop, 1);
      end
      if (k == 9) check_val("out_valid_early", out_valid, 0);
      if (k == 10) begin
        check_val("out_valid", out_valid, 1);
        check_val("out_vec", out_vec, vec);
        check_val("out_class", out_class, cls);
        check_val("busy_done", busy, 0);
      end
    end
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_val("out_valid_cleared", out_valid, 0);
    check_val("in_ready_back", in_ready, 1);
  endtask

  initial begin
    int seen_valid;
    rst = 1'b1; in_valid = 1'b0; in_features = 18'd0; cfg_we = 1'b0;
    cfg_neur = 3'd0; cfg_slot = 3'd0; cfg_idx = 4'd0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_neur_in", neur_in, 0);
    check_val("rst_out_vec", out_vec, 0);
    check_val("rst_cfg_drop", cfg_drop, 0);

    // Default routing, majority positive then negative.
    start(F1, 5'b01101, 1'b0, 4'd0);
    run_body(14'h24E4, 14'h3939, 5'b01101, 1'b1, 1'b0);
    finish_out();
    start(F1, 5'b00010, 1'b0, 4'd0);
    run_body(14'h24E4, 14'h3939, 5'b00010, 1'b0, 1'b0);
    finish_out();

    // Standalone config write in IDLE: slot 0 of neuron 0 reads feature 8.
    @(negedge clk);
    cfg_we = 1'b1; cfg_neur = 3'd0; cfg_slot = 3'd0; cfg_idx = 4'd8;
    @(negedge clk);
    cfg_we = 1'b0;
    start(F2, 5'b00000, 1'b0, 4'd0);
    run_body(14'h24E7, 14'h3939, 5'b00000, 1'b0, 1'b0);
    finish_out();

    // Write lands together with accept; out-of-range index gives zero operand.
    start(F3, 5'b00000, 1'b1, 4'd12);
    run_body(14'h3FFC, 14'h3FFF, 5'b00000, 1'b0, 1'b0);
    check_val("cfg_drop_idle", cfg_drop, 0);
    finish_out();

    // Reset in the middle of neuron 2's capture cycle.
    start(F3, 5'b11111, 1'b0, 4'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("mid_rst_in_ready", in_ready, 1);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_neur_in", neur_in, 0);
    check_val("mid_rst_out_vec", out_vec, 0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check_val("mid_rst_no_valid", seen_valid, 0);
    check_val("mid_rst_idle", in_ready, 1);

    // Table back at defaults; a write while busy is dropped.
    start(F2, 5'b10101, 1'b0, 4'd0);
    run_body(14'h24E4, 14'h3939, 5'b10101, 1'b1, 1'b1);
    finish_out();
    start(F2, 5'b11110, 1'b0, 4'd0);
    run_body(14'h24E4, 14'h3939, 5'b11110, 1'b1, 1'b0);
    check_val("cfg_drop_sticky", cfg_drop, 1);

    // Backpressure in DONE with the next sample already offered.
    in_features = F1;
    in_valid    = 1'b1;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      check_val("bp_out_valid", out_valid, 1);
      check_val("bp_out_vec", out_vec, 5'b11110);
      check_val("bp_out_class", out_class, 1);
      check_val("bp_in_ready", in_ready, 0);
    end
    fire_mask = 5'b00111;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_val("bp_idle_in_ready", in_ready, 1);
    check_val("bp_idle_busy", busy, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_val("bp_accepted_busy", busy, 1);
    check_val("bp_accepted_in_ready", in_ready, 0);
    run_body(14'h24E4, 14'h3939, 5'b00111, 1'b1, 1'b0);
    finish_out();
    check_val("cfg_drop_final", cfg_drop, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tnn_neuron_sequencer.md
# tnn_neuron_sequencer

Time-multiplexed controller that shares one combinational approximate TNN neuron (seven 2-bit operands a..g, 1-bit firing output) among NUM_NEUR logical neurons of a classifier layer. It accepts one feature sample per handshake and routes a configurable feature subset to the shared neuron for each logical neuron in turn. It collects the firing bits and emits the firing vector plus a majority-vote class. It sits between the feature front end and the class output of the breast-cancer TNN.

## Interface
Parameters:
- NUM_FEAT, 9, number of 2-bit input features
- NUM_NEUR, 5, logical neurons sequenced onto the shared unit (2..8)
- SEL_W, 4, feature-index width (≥ clog2(NUM_FEAT))

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  sample offered
- in_ready  out  1  sample accepted when in_valid & in_ready
- in_features  in  2*NUM_FEAT  feature i at [2i+1:2i]
- cfg_we  in  1  write one routing entry
- cfg_neur  in  3  logical neuron index
- cfg_slot  in  3  operand slot 0..6 (= a..g)
- cfg_idx  in  SEL_W  feature index for that slot
- neur_in  out  14  registered operands to shared neuron, slot s at [2s+1:2s]
- neur_out  in  1  shared neuron firing bit (combinational from neur_in)
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid & out_ready
- out_vec  out  NUM_NEUR  firing bit of logical neuron n at bit n
- out_class  out  1  majority vote
- busy  out  1  high in DRIVE/CAPT
- cfg_drop  out  1  sticky: a config write was dropped

## Operation
- FSM states: IDLE, DRIVE, CAPT, DONE. in_ready = (state==IDLE); out_valid = (state==DONE); busy = DRIVE|CAPT.
- IDLE: on in handshake, latch in_features, n<=0, go DRIVE.
- DRIVE: load neur_in with operands from the routing table for neuron n, go CAPT.
- CAPT: out_vec[n] <= neur_out. If n==NUM_NEUR-1, compute out_class and go DONE; otherwise n<=n+1 and go DRIVE.
- DONE: hold out_vec, out_class and neur_in. On out_ready go IDLE.
- out_class = (popcount(out_vec) > NUM_NEUR/2, integer floor). For NUM_NEUR=5 this requires ≥3.
- Routing table holds NUM_NEUR×7 entries of SEL_W bits. Default entry (n,s) = (n+s) mod NUM_FEAT.
- Config writes take effect at the next edge when state is IDLE or DONE.
  - A write during DRIVE/CAPT is dropped and sets cfg_drop.
  - A write with cfg_neur ≥ NUM_NEUR or cfg_slot==7 is ignored silently.
- An entry with idx ≥ NUM_FEAT drives that operand as 2'b00.
- out_vec bits are not cleared between samples. Each bit is overwritten in its CAPT cycle.

## Timing
- Reset (async, any state, including mid-evaluation): state IDLE, all outputs 0 except in_ready=1, routing table returns to defaults, latched features 0. The sample in progress is discarded and no out_valid is produced for it.
- Accept at edge T: neur_in for neuron n is valid from edge T+1+2n. neur_out for neuron n is sampled at edge T+2+2n.
- out_valid rises after edge T+2*NUM_NEUR (10 cycles at default).
- Throughput: a new sample is accepted ≥1 cycle after the out handshake, because in_ready is low in DONE. Minimum period is 2*NUM_NEUR+2 cycles.
- out_valid stays high with out_vec/out_class stable until out_ready. No timeout.
- A simultaneous cfg_we and in handshake in IDLE: the write lands first and the sample uses the new table.

## Test plan
- Reset check: assert rst mid-CAPT of neuron 2 -> next cycle in_ready=1, out_valid=0, neur_in=0, busy=0, table at defaults; read back via sample with default routing.
- Default routing: feature i = i mod 4, accept -> first DRIVE produces neur_in=14'h24E4 (slots 0..6 = 0,1,2,3,0,1,2); with stub firing for n∈{0,2,3}, out_vec=5'b01101, out_class=1, out_valid 10 cycles after accept.
- Majority-negative: stub fires only for n=1 -> out_vec=5'b00010, out_class=0.
- Config write: in IDLE, write (neur 0, slot 0, idx 8) with feature 8 = 2'b11 -> neuron 0 neur_in[1:0]=2'b11. Write idx 12 -> operand 2'b00. cfg_drop stays 0.
- Busy write: cfg_we during CAPT -> table unchanged (next sample shows default operands), cfg_drop=1 until reset.
- Backpressure: out_ready low 7 cycles in DONE -> outputs stable, in_ready=0, an in_valid held high is accepted exactly one cycle after out handshake.
